status_event_ctrl: RTL and testbench
====================================

STATUS_EVENT_CTRL -- requirements
Module: status_event_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 8, number of active event sources (1..8); bits at and above NUM_SRC are inert.
REQ-002 SHALL have parameter EDGE_MODE[7:0], default 8'h00; 1 = bit is a sticky rising-edge event, 0 = bit is a transparent level.
REQ-003 SHALL have parameter INT_MASK_INIT[7:0], default 8'h7F, the mask value loaded at reset.
REQ-004 SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port src_in  input  8  raw event/level inputs, synchronous to clock.
REQ-007 SHALL have port mask_wr  input  1  one-cycle strobe that loads mask_data into the interrupt mask.
REQ-008 SHALL have port mask_data  input  8  new interrupt mask value.
REQ-009 SHALL have port rd_req  input  1  level request from the CPU side to snapshot and clear status.
REQ-010 SHALL have port rd_ack  output  1  one-cycle pulse; rd_data is valid in that cycle.
REQ-011 SHALL have port rd_data  output  8  status snapshot, held until the next snapshot.
REQ-012 SHALL have port intr  output  1  registered interrupt request.
REQ-013 SHALL have port pending  output  1  high when (status & mask) != 0, regardless of FSM state.

Function
REQ-014 SHALL keep src_q, src_in registered once per clock; edge bit i = src_in[i] & ~src_q[i].
REQ-015 SHALL set sticky[i] on the edge where edge bit i = 1 for EDGE_MODE[i] = 1 bits; status[i] = sticky[i].
REQ-016 SHALL make status[i] = src_q[i] for EDGE_MODE[i] = 0 bits; these bits are never cleared by a read.
REQ-017 SHALL force status bits >= NUM_SRC and mask bits >= NUM_SRC to 0.
REQ-018 SHALL implement FSM states IDLE, ARMED, SNAP, ACK and HOLD (HOLD exists only per REQ-030).
REQ-019 SHALL transition IDLE->ARMED when pending = 1 and rd_req = 0; SHALL transition ARMED->IDLE when pending drops (mask write or level deassert).
REQ-020 SHALL drive intr = 1 exactly while in ARMED; intr rises 2 clocks after src_in first samples high for an unmasked edge bit.
REQ-021 SHALL accept rd_req in IDLE, ARMED or HOLD only when rd_req was sampled low at least once since the previous rd_ack; acceptance goes to SNAP.
REQ-022 SHALL, in SNAP, load rd_data <= status and clear exactly the edge-mode sticky bits that were 1 in the snapshot.
REQ-023 SHALL OR in an edge arriving in the SNAP cycle after the clear, so that edge is retained.
REQ-024 SHALL pulse rd_ack = 1 in ACK (one cycle after SNAP), then go to HOLD if enabled, else IDLE.
REQ-025 SHALL update the mask on the clock after mask_wr; a mask write in any state SHALL take effect without aborting SNAP/ACK.

Reset
REQ-026 SHALL, while reset = 1, force state = IDLE, src_q = 0, sticky = 0, mask = INT_MASK_INIT, rd_data = 0, rd_ack = 0, intr = 0 and the holdoff counter = 0.
REQ-027 SHALL, on reset assertion mid-SNAP/ACK, suppress the rd_ack pulse; the requester re-issues rd_req.
REQ-028 SHALL resume normal operation from IDLE on the first clock edge after reset deasserts.

Configuration
REQ-029 SHALL make STATUS_EVENT_CTRL_COALESCE_EN the sole build macro.
REQ-030 SHALL, with STATUS_EVENT_CTRL_COALESCE_EN defined, add parameter HOLDOFF_CYC (default 16, 8-bit) and state HOLD.
- ACK->HOLD, counter loaded with HOLDOFF_CYC.
- Decrements each clock; leaves HOLD->IDLE at 0.
- intr is held 0 while in HOLD; sticky bits keep accumulating.
- An accepted rd_req exits HOLD to SNAP.
REQ-031 SHALL, with the macro undefined, go ACK->IDLE directly and contain no counter logic.

Structure
REQ-032 SHALL put the FSM state enum, the width constant (8) and the default mask constant in package status_event_pkg.
REQ-033 SHALL implement per-bit edge detect and sticky/clear in sub-module status_edge_capture, instantiated once as 8 bits wide.

Verification
REQ-034 SHALL cover: EDGE_MODE = 8'h01, mask 8'h7F, src_in[0] pulse 1 cycle -> intr high 2 clocks later; rd_req -> rd_data = 8'h01, rd_ack 1 cycle, intr low, sticky 0.
REQ-035 SHALL cover: src_in[0] rises in the SNAP cycle of a read -> rd_data bit0 reflects the prior value, and sticky[0] = 1 after ACK with intr re-asserting.
REQ-036 SHALL cover: level bit 7 held high, mask 8'h7F -> pending = 0, intr = 0; mask_wr 8'hFF -> intr = 1 two clocks later; mask_wr 8'h7F -> intr = 0.
REQ-037 SHALL cover: NUM_SRC = 4, src_in = 8'hF0 edges -> status stays 8'h00, no intr.
REQ-038 SHALL cover: with COALESCE_EN and HOLDOFF_CYC = 4, an edge arriving 1 clock after ACK -> intr stays 0 for 4 clocks, then rises.
REQ-039 SHALL cover: reset asserted in SNAP -> no rd_ack, all outputs at reset values; rd_req held high across reset -> no snapshot until rd_req toggles low then high.

Source files
------------

// File: rtl/status_event_pkg.sv
// Shared types and constants for status_event_ctrl.
// The HOLD state is only part of the state enum when STATUS_EVENT_CTRL_COALESCE_EN is defined.
package status_event_pkg;

  localparam int SEC_WIDTH = 8;
  localparam logic [SEC_WIDTH-1:0] SEC_DEFAULT_MASK = 8'h7F;

`ifdef STATUS_EVENT_CTRL_COALESCE_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_SNAP  = 3'd2,
    ST_ACK   = 3'd3,
    ST_HOLD  = 3'd4
  } sec_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_SNAP  = 3'd2,
    ST_ACK   = 3'd3
  } sec_state_e;
`endif

  // Ones in the low num_src bit positions; num_src is expected to be 1..8.
  function automatic logic [SEC_WIDTH-1:0] sec_src_valid(input int num_src);
    logic [15:0] ones;
    ones = (16'd1 << num_src) - 16'd1;
    return ones[SEC_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/status_edge_capture.sv
// Per-bit input register, rising-edge detect and sticky event capture with clear.
// A clear and a fresh edge in the same cycle leave the sticky bit set.
module status_edge_capture
  import status_event_pkg::*;
#(
  parameter int WIDTH = SEC_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] src_in,
  input  logic [WIDTH-1:0] edge_en,
  input  logic [WIDTH-1:0] clear,
  output logic [WIDTH-1:0] src_q,
  output logic [WIDTH-1:0] sticky_q
);

  logic [WIDTH-1:0] src_d;
  logic [WIDTH-1:0] sticky_d;

  always_comb begin
    src_d    = src_in;
    sticky_d = (sticky_q & ~clear) | (src_in & ~src_q & edge_en);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      src_q    <= '0;
      sticky_q <= '0;
    end else begin
      src_q    <= src_d;
      sticky_q <= sticky_d;
    end
  end

endmodule

// File: rtl/status_event_ctrl.sv
// Status/event controller: sticky edge and level status, interrupt mask, snapshot-and-clear read.
// Build macro STATUS_EVENT_CTRL_COALESCE_EN adds a post-read HOLD state with an HOLDOFF_CYC counter.
module status_event_ctrl
  import status_event_pkg::*;
#(
  parameter int         NUM_SRC       = 8,
  parameter logic [7:0] EDGE_MODE     = 8'h00,
  parameter logic [7:0] INT_MASK_INIT = SEC_DEFAULT_MASK
`ifdef STATUS_EVENT_CTRL_COALESCE_EN
  , parameter logic [7:0] HOLDOFF_CYC = 8'd16
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] src_in,
  input  logic       mask_wr,
  input  logic [7:0] mask_data,
  input  logic       rd_req,
  output logic       rd_ack,
  output logic [7:0] rd_data,
  output logic       intr,
  output logic       pending
);

  localparam logic [7:0] VALID_MASK = sec_src_valid(NUM_SRC);
  localparam logic [7:0] EDGE_BITS  = EDGE_MODE & VALID_MASK;
  localparam logic [7:0] LEVEL_BITS = ~EDGE_MODE & VALID_MASK;

  sec_state_e state_q, state_d;
  logic [7:0] mask_q, mask_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       intr_q, intr_d;
  logic       rd_ack_q, rd_ack_d;
  logic       req_low_q, req_low_d;
  logic [7:0] src_q, sticky_q, clear, status;
  logic       accept;
`ifdef STATUS_EVENT_CTRL_COALESCE_EN
  logic [7:0] cnt_q, cnt_d;
`endif

  status_edge_capture #(
    .WIDTH(SEC_WIDTH)
  ) u_capture (
    .clock   (clock),
    .reset   (reset),
    .src_in  (src_in),
    .edge_en (EDGE_BITS),
    .clear   (clear),
    .src_q   (src_q),
    .sticky_q(sticky_q)
  );

  // Only edge bits present in the snapshot are cleared; an edge landing in SNAP survives.
  assign status  = (sticky_q & EDGE_BITS) | (src_q & LEVEL_BITS);
  assign pending = |(status & mask_q);
  assign clear   = (state_q == ST_SNAP) ? (status & EDGE_BITS) : 8'h00;
  assign accept  = req_low_q & rd_req;

  always_comb begin
    state_d   = state_q;
    rd_data_d = rd_data_q;
    req_low_d = req_low_q | ~rd_req;
    mask_d    = mask_wr ? (mask_data & VALID_MASK) : mask_q;
`ifdef STATUS_EVENT_CTRL_COALESCE_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept)                state_d = ST_SNAP;
        else if (pending & ~rd_req) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (accept)        state_d = ST_SNAP;
        else if (!pending) state_d = ST_IDLE;
      end
      ST_SNAP: begin
        rd_data_d = status;
        state_d   = ST_ACK;
      end
      ST_ACK: begin
        // A new request must be seen low after this acknowledge before it is accepted.
        req_low_d = ~rd_req;
`ifdef STATUS_EVENT_CTRL_COALESCE_EN
        state_d   = ST_HOLD;
        cnt_d     = HOLDOFF_CYC;
`else
        state_d   = ST_IDLE;
`endif
      end
`ifdef STATUS_EVENT_CTRL_COALESCE_EN
      ST_HOLD: begin
        if (accept) begin
          state_d = ST_SNAP;
          cnt_d   = 8'd0;
        end else if (cnt_q <= 8'd1) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d   = cnt_q - 8'd1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    intr_d   = (state_d == ST_ARMED);
    rd_ack_d = (state_d == ST_ACK);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      mask_q    <= INT_MASK_INIT & VALID_MASK;
      rd_data_q <= 8'h00;
      intr_q    <= 1'b0;
      rd_ack_q  <= 1'b0;
      req_low_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      rd_data_q <= rd_data_d;
      intr_q    <= intr_d;
      rd_ack_q  <= rd_ack_d;
      req_low_q <= req_low_d;
    end
  end

`ifdef STATUS_EVENT_CTRL_COALESCE_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= 8'd0;
    else       cnt_q <= cnt_d;
  end
`endif

  assign rd_ack  = rd_ack_q;
  assign rd_data = rd_data_q;
  assign intr    = intr_q;

endmodule

// File: tb/tb_status_event_ctrl.sv
// Scoreboard bench for status_event_ctrl: directed scenarios followed by random traffic.
// Reads push expected snapshots into a queue; a separate monitor pops them on rd_ack.
module tb_status_event_ctrl;

  localparam int         NUM_SRC    = 7;
  localparam logic [7:0] EDGE_MODE  = 8'h8F;
  localparam logic [7:0] MASK_INIT  = 8'h7F;
  localparam logic [7:0] VALID      = 8'h7F;
  localparam logic [7:0] EDGE_BITS  = EDGE_MODE & VALID;
  localparam logic [7:0] LEVEL_BITS = ~EDGE_MODE & VALID;
  localparam int         HOLD_CYC   = 4;
`ifdef STATUS_EVENT_CTRL_COALESCE_EN
  localparam bit HOLD_ON = 1'b1;
`else
  localparam bit HOLD_ON = 1'b0;
`endif

  localparam int P_QUIET = 0;
  localparam int P_INTR  = 1;
  localparam int P_SNAP  = 2;
  localparam int P_ACK   = 3;
  localparam int P_HOLD  = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] src_in = 8'h00;
  logic       mask_wr = 1'b0;
  logic [7:0] mask_data = 8'h00;
  logic       rd_req = 1'b0;
  logic       rd_ack;
  logic [7:0] rd_data;
  logic       intr;
  logic       pending;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  // Reference model: what software should observe, tracked per clock.
  logic [7:0] m_prev = 8'h00;
  logic [7:0] m_events = 8'h00;
  logic [7:0] m_mask = MASK_INIT & VALID;
  int         m_phase = P_QUIET;
  bit         m_req_low = 1'b0;
  int         m_hold = 0;

  status_event_ctrl #(
    .NUM_SRC      (NUM_SRC),
    .EDGE_MODE    (EDGE_MODE),
    .INT_MASK_INIT(MASK_INIT)
`ifdef STATUS_EVENT_CTRL_COALESCE_EN
    , .HOLDOFF_CYC(8'(HOLD_CYC))
`endif
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .src_in   (src_in),
    .mask_wr  (mask_wr),
    .mask_data(mask_data),
    .rd_req   (rd_req),
    .rd_ack   (rd_ack),
    .rd_data  (rd_data),
    .intr     (intr),
    .pending  (pending)
  );

  initial forever #5 clock = ~clock;

  function automatic logic [7:0] modelStatus();
    return (m_events & EDGE_BITS) | (m_prev & LEVEL_BITS);
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%02h expected=%02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_prev    = 8'h00;
    m_events  = 8'h00;
    m_mask    = MASK_INIT & VALID;
    m_phase   = P_QUIET;
    m_req_low = 1'b0;
    m_hold    = 0;
    exp_q.delete();
  endtask

  task automatic modelStep(input logic [7:0] s, input logic mw, input logic [7:0] md, input logic rq);
    logic [7:0] snap;
    logic [7:0] fresh;
    bit         pend;
    bit         take;
    int         nxt;
    snap  = modelStatus();
    pend  = (snap & m_mask) != 8'h00;
    take  = m_req_low && rq && (m_phase == P_QUIET || m_phase == P_INTR || m_phase == P_HOLD);
    fresh = s & ~m_prev & EDGE_BITS;
    nxt   = m_phase;
    if (m_phase == P_QUIET) begin
      if (take) nxt = P_SNAP;
      else if (pend && !rq) nxt = P_INTR;
    end else if (m_phase == P_INTR) begin
      if (take) nxt = P_SNAP;
      else if (!pend) nxt = P_QUIET;
    end else if (m_phase == P_SNAP) begin
      nxt = P_ACK;
      exp_q.push_back(snap);
    end else if (m_phase == P_ACK) begin
      nxt = HOLD_ON ? P_HOLD : P_QUIET;
      m_hold = HOLD_CYC;
    end else begin
      if (take) nxt = P_SNAP;
      else begin
        m_hold = m_hold - 1;
        if (m_hold <= 0) nxt = P_QUIET;
      end
    end
    if (m_phase == P_SNAP) m_events = (m_events & ~snap) | fresh;
    else                   m_events = m_events | fresh;
    m_req_low = (m_phase == P_ACK) ? !rq : (m_req_low || !rq);
    if (mw) m_mask = md & VALID;
    m_prev  = s;
    m_phase = nxt;
  endtask

  task automatic applyStimulus(input logic [7:0] s, input logic mw, input logic [7:0] md, input logic rq);
    src_in    = s;
    mask_wr   = mw;
    mask_data = md;
    rd_req    = rq;
    @(posedge clock);
    modelStep(s, mw, md, rq);
    #1;
    checkOutput("intr", {7'd0, intr}, {7'd0, m_phase == P_INTR});
    checkOutput("rd_ack", {7'd0, rd_ack}, {7'd0, m_phase == P_ACK});
    checkOutput("pending", {7'd0, pending}, {7'd0, (modelStatus() & m_mask) != 8'h00});
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_rd_data"}, rd_data, 8'h00);
    checkOutput({tag, "_rd_ack"}, {7'd0, rd_ack}, 8'h00);
    checkOutput({tag, "_intr"}, {7'd0, intr}, 8'h00);
    checkOutput({tag, "_pending"}, {7'd0, pending}, 8'h00);
  endtask

  // Called one time unit after an active edge; asserts reset mid-cycle.
  task automatic doReset();
    #2 reset = 1'b1;
    #1;
    modelReset();
    checkResetOutputs("reset_mid");
    @(posedge clock);
    #1;
    checkResetOutputs("reset_hold");
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic idleCycles(input int n, input logic [7:0] s);
    for (int i = 0; i < n; i++) applyStimulus(s, 1'b0, 8'h00, 1'b0);
  endtask

  // Monitor: every acknowledged read must match the oldest expected snapshot.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (rd_ack === 1'b1) begin
        if (exp_q.size() == 0) checkOutput("unexpected_rd_ack", {7'd0, rd_ack}, 8'h00);
        else                   checkOutput("rd_data", rd_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #12;
    checkResetOutputs("reset_init");
    @(negedge clock);
    reset = 1'b0;

    // Single edge pulse on bit 0, interrupt two clocks later, then read and clear.
    applyStimulus(8'h01, 1'b0, 8'h00, 1'b0);
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b0);
    checkOutput("intr_after_2clk", {7'd0, intr}, 8'h01);
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b1);
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b1);
    checkOutput("first_read_data", rd_data, 8'h01);
    checkOutput("intr_low_in_ack", {7'd0, intr}, 8'h00);
    idleCycles(7, 8'h00);
    checkOutput("sticky_cleared", {7'd0, pending}, 8'h00);

    // Edge on bit 1 lands in the SNAP cycle and must survive the clear.
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b1);
    applyStimulus(8'h02, 1'b0, 8'h00, 1'b1);
    checkOutput("snap_edge_data", rd_data, 8'h00);
    idleCycles(7, 8'h02);
    checkOutput("snap_edge_kept", {7'd0, intr}, 8'h01);
    applyStimulus(8'h02, 1'b0, 8'h00, 1'b1);
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b1);
    idleCycles(7, 8'h00);

    // Level bit 6 gated by the mask.
    applyStimulus(8'h00, 1'b1, 8'h3F, 1'b0);
    idleCycles(3, 8'h40);
    checkOutput("level_masked", {7'd0, intr}, 8'h00);
    applyStimulus(8'h40, 1'b1, 8'hFF, 1'b0);
    applyStimulus(8'h40, 1'b0, 8'h00, 1'b0);
    checkOutput("level_unmasked", {7'd0, intr}, 8'h01);
    applyStimulus(8'h40, 1'b1, 8'h3F, 1'b0);
    applyStimulus(8'h40, 1'b0, 8'h00, 1'b0);
    checkOutput("level_remasked", {7'd0, intr}, 8'h00);

    // Bit 7 is beyond NUM_SRC: edges there must never show up.
    applyStimulus(8'h80, 1'b1, 8'hFF, 1'b0);
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b0);
    applyStimulus(8'h80, 1'b0, 8'h00, 1'b0);
    idleCycles(2, 8'h80);
    checkOutput("inert_bit7", {7'd0, pending}, 8'h00);
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b1);
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b1);
    idleCycles(7, 8'h00);

    // Edge one clock after the acknowledge (held off when coalescing is built in).
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b1);
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b1);
    applyStimulus(8'h04, 1'b0, 8'h00, 1'b0);
    idleCycles(8, 8'h04);
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b1);
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b1);
    idleCycles(7, 8'h00);

    // Reset in SNAP with rd_req held across it: no acknowledge, no new snapshot until re-issued.
    applyStimulus(8'h08, 1'b0, 8'h00, 1'b1);
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(8'h00, 1'b0, 8'h00, 1'b1);
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b0);
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b1);
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b1);
    idleCycles(7, 8'h00);

    // Random traffic.
    for (int c = 0; c < 800; c++) begin
      logic [7:0] s;
      logic       mw;
      logic [7:0] md;
      logic       rq;
      s  = src_in;
      if ($urandom_range(0, 2) == 0) s = 8'($urandom);
      mw = ($urandom_range(0, 15) == 0);
      md = 8'($urandom);
      rq = rd_req;
      if ($urandom_range(0, 4) == 0) rq = ~rd_req;
      applyStimulus(s, mw, md, rq);
      if (c == 400) doReset();
    end

    idleCycles(12, 8'h00);
    checkOutput("scoreboard_empty", 8'(exp_q.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
